// File: rtl/shcollect_pkg.sv
// Shared definitions for the serial-to-parallel collector at the Booth
// shift-register output.
package shcollect_pkg;

  localparam int W_DEF  = 12;
  localparam int CW_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/shcollect_if.sv
// Collector bus: start/serial-in/ack from the environment,
// shift enable and assembled word back out.
interface shcollect_if #(
  parameter int W = 12
) ();

  logic         start;
  logic         serin;
  logic         sh;
  logic         busy;
  logic [W-1:0] parout;
  logic         valid;
  logic         ack;

  modport master (
    output start, serin, ack,
    input  sh, busy, parout, valid
  );

  modport slave (
    input  start, serin, ack,
    output sh, busy, parout, valid
  );

endinterface

// File: rtl/shcollect_ctrl.sv
// Collection FSM and bit counter.
// Produces the shift enable, valid flag and a word-clear strobe.
module shcollect_ctrl
  import shcollect_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_ack,
  output logic o_sh,
  output logic o_busy,
  output logic o_valid,
  output logic o_load
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic          w_last;
  logic          w_load;

  assign w_last = (r_count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        // A start without ack must not overwrite the word being held.
        if (i_ack) begin
          if (i_start) begin
            w_load = 1'b1;
            w_next = S_SHIFT;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= '0;
    end else if (r_state == S_SHIFT) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  assign o_sh    = (r_state == S_SHIFT);
  assign o_busy  = (r_state == S_SHIFT);
  assign o_valid = (r_state == S_HOLD);
  assign o_load  = w_load;

endmodule

// File: rtl/shcollect.sv
// Serial-to-parallel collector: reads the upstream register LSB-first and
// presents the W-bit word with a valid/ack handshake.
module shcollect
  import shcollect_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input logic         clk,
  input logic         rst,
  shcollect_if.slave  bus
);

  logic         w_sh;
  logic         w_busy;
  logic         w_valid;
  logic         w_load;
  logic [W-1:0] r_par;

  shcollect_ctrl #(
    .W  (W),
    .CW (CW)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .i_start (bus.start),
    .i_ack   (bus.ack),
    .o_sh    (w_sh),
    .o_busy  (w_busy),
    .o_valid (w_valid),
    .o_load  (w_load)
  );

  // Right shift so the first bit received ends up in bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= '0;
    end else if (w_load) begin
      r_par <= '0;
    end else if (w_sh) begin
      r_par <= {bus.serin, r_par[W-1:1]};
    end
  end

  assign bus.sh     = w_sh;
  assign bus.busy   = w_busy;
  assign bus.valid  = w_valid;
  assign bus.parout = r_par;

endmodule
